// File: rtl/tmds_channel_decoder_if.sv
// Symbol input and decoded outputs of one TMDS receive channel.
// master = symbol source / decode sink side, slave = the decoder itself.
interface tmds_channel_decoder_if;
    logic [9:0] tmds_sym;
    logic       bitslip;
    logic       locked;
    logic [7:0] video_data;
    logic [1:0] ctrl;
    logic       ctrl_valid;
    logic [3:0] terc4;
    logic       terc4_valid;

    modport master (
        output tmds_sym,
        input  bitslip, locked, video_data, ctrl, ctrl_valid, terc4, terc4_valid
    );

    modport slave (
        input  tmds_sym,
        output bitslip, locked, video_data, ctrl, ctrl_valid, terc4, terc4_valid
    );
endinterface

// File: rtl/tmds_channel_decoder.sv
// TMDS channel receiver: word alignment via control-token runs plus video/control/TERC4 decode.
// Latency: 2 cycles symbol to decode outputs. Backpressure: none, one symbol accepted every cycle.
module tmds_channel_decoder #(
    parameter int LOCK_RUN    = 8,
    parameter int SEARCH_TMO  = 1024,
    parameter int SLIP_SETTLE = 4,
    parameter int LOSS_TMO    = 2048
) (
    input  logic                  clk_pix,
    input  logic                  rst_in,
    tmds_channel_decoder_if.slave dec
);
    localparam int MAX_A = (LOCK_RUN > SEARCH_TMO) ? LOCK_RUN : SEARCH_TMO;
    localparam int MAX_B = (SLIP_SETTLE > LOSS_TMO) ? SLIP_SETTLE : LOSS_TMO;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_P) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t RUN_LAST    = cnt_t'(LOCK_RUN - 1);
    localparam cnt_t TMO_LAST    = cnt_t'(SEARCH_TMO - 1);
    localparam cnt_t SETTLE_LAST = cnt_t'(SLIP_SETTLE);
    localparam cnt_t GAP_LAST    = cnt_t'(LOSS_TMO - 1);
    localparam cnt_t CNT_MAX     = {CW{1'b1}};

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] video;
        logic [1:0] ctrl;
        logic       ctrl_vld;
        logic [3:0] terc4;
        logic       terc4_vld;
    } dec_t;

    logic [9:0] sym_q;
    logic [7:0] v;
    dec_t       dec_d;
    dec_t       dec_q;
    logic       tok;

    state_t state, state_n;
    cnt_t   run_q, run_n;
    cnt_t   tmo_q, tmo_n;
    cnt_t   settle_q, settle_n;
    cnt_t   gap_q, gap_n;
    logic   bitslip_q, bitslip_n;
    logic   locked_q, locked_n;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_MAX) ? c : c + cnt_t'(1);
    endfunction

    always_comb begin
        dec_d = '0;
        v     = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
        dec_d.video[0] = v[0];
        for (int i = 1; i < 8; i++) begin
            dec_d.video[i] = sym_q[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        end
        case (sym_q)
            10'b1101010100: begin dec_d.ctrl = 2'd0; dec_d.ctrl_vld = 1'b1; end
            10'b0010101011: begin dec_d.ctrl = 2'd1; dec_d.ctrl_vld = 1'b1; end
            10'b0101010100: begin dec_d.ctrl = 2'd2; dec_d.ctrl_vld = 1'b1; end
            10'b1010101011: begin dec_d.ctrl = 2'd3; dec_d.ctrl_vld = 1'b1; end
            default: ;
        endcase
        // TERC4 codes are disjoint from the control tokens, so both flags never fire together
        dec_d.terc4_vld = 1'b1;
        case (sym_q)
            10'b1010011100: dec_d.terc4 = 4'd0;
            10'b1001100011: dec_d.terc4 = 4'd1;
            10'b1011100100: dec_d.terc4 = 4'd2;
            10'b1011100010: dec_d.terc4 = 4'd3;
            10'b0101110001: dec_d.terc4 = 4'd4;
            10'b0100011110: dec_d.terc4 = 4'd5;
            10'b0110001110: dec_d.terc4 = 4'd6;
            10'b0100111100: dec_d.terc4 = 4'd7;
            10'b1011001100: dec_d.terc4 = 4'd8;
            10'b0100111001: dec_d.terc4 = 4'd9;
            10'b0110011100: dec_d.terc4 = 4'd10;
            10'b1011000110: dec_d.terc4 = 4'd11;
            10'b1010001110: dec_d.terc4 = 4'd12;
            10'b1001110001: dec_d.terc4 = 4'd13;
            10'b0101100011: dec_d.terc4 = 4'd14;
            10'b1011000011: dec_d.terc4 = 4'd15;
            default:        dec_d.terc4_vld = 1'b0;
        endcase
    end

    assign tok = dec_d.ctrl_vld;

    always_comb begin
        state_n   = state;
        run_n     = run_q;
        tmo_n     = tmo_q;
        settle_n  = settle_q;
        gap_n     = gap_q;
        bitslip_n = 1'b0;
        case (state)
            SEARCH: begin
                run_n = tok ? sat_inc(run_q) : '0;
                tmo_n = sat_inc(tmo_q);
                if (tok && (run_q == RUN_LAST)) begin
                    state_n = LOCKED;
                    run_n   = '0;
                    tmo_n   = '0;
                    gap_n   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_n   = SLIP;
                    bitslip_n = 1'b1;
                    run_n     = '0;
                    tmo_n     = '0;
                    settle_n  = '0;
                end
            end
            SLIP: begin
                // Pulse cycle plus SLIP_SETTLE cycles of stale symbols are ignored
                settle_n = sat_inc(settle_q);
                if (settle_q == SETTLE_LAST) begin
                    state_n  = SEARCH;
                    settle_n = '0;
                    run_n    = '0;
                    tmo_n    = '0;
                end
            end
            LOCKED: begin
                if (tok) begin
                    gap_n = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_n = SEARCH;
                    gap_n   = '0;
                    run_n   = '0;
                    tmo_n   = '0;
                end else begin
                    gap_n = sat_inc(gap_q);
                end
            end
            default: state_n = SEARCH;
        endcase
        locked_n = (state_n == LOCKED);
    end

    always_ff @(posedge clk_pix) begin
        if (rst_in) begin
            sym_q     <= '0;
            dec_q     <= '0;
            state     <= SEARCH;
            run_q     <= '0;
            tmo_q     <= '0;
            settle_q  <= '0;
            gap_q     <= '0;
            bitslip_q <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            sym_q     <= dec.tmds_sym;
            dec_q     <= dec_d;
            state     <= state_n;
            run_q     <= run_n;
            tmo_q     <= tmo_n;
            settle_q  <= settle_n;
            gap_q     <= gap_n;
            bitslip_q <= bitslip_n;
            locked_q  <= locked_n;
        end
    end

    assign dec.bitslip     = bitslip_q;
    assign dec.locked      = locked_q;
    assign dec.video_data  = dec_q.video;
    assign dec.ctrl        = dec_q.ctrl;
    assign dec.ctrl_valid  = dec_q.ctrl_vld;
    assign dec.terc4       = dec_q.terc4;
    assign dec.terc4_valid = dec_q.terc4_vld;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: reset, decode tables, latency, lock/loss timing, bitslip alignment.
module tb_tmds_channel_decoder;
    logic clk_pix = 1'b0;
    logic rst_in  = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [9:0] TOK00 = 10'h354;
    localparam logic [9:0] TOK01 = 10'h0AB;
    localparam logic [9:0] TOK10 = 10'h154;
    localparam logic [9:0] TOK11 = 10'h2AB;
    localparam logic [9:0] VID00 = 10'h100;

    logic [9:0] terc4_tab [16] = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2,
                                   10'h171, 10'h11E, 10'h18E, 10'h13C,
                                   10'h2CC, 10'h139, 10'h19C, 10'h2C6,
                                   10'h28E, 10'h271, 10'h163, 10'h2C3};

    always #5 clk_pix = ~clk_pix;

    tmds_channel_decoder_if bus ();

    tmds_channel_decoder dut (
        .clk_pix (clk_pix),
        .rst_in  (rst_in),
        .dec     (bus)
    );

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    function automatic logic [9:0] rotr(input logic [9:0] s, input int r);
        logic [19:0] w;
        w = {s, s} >> r;
        return w[9:0];
    endfunction

    function automatic logic [9:0] line_sym(input int h);
        logic [7:0] p;
        p = h[7:0];
        if (h < 640) return {2'b01, p};
        if (h < 656) return TOK00;
        if (h < 752) return TOK01;
        return TOK00;
    endfunction

    task automatic pulse_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        bus.tmds_sym = TOK00;
        repeat (3) tick();
        checks++;
        if ({bus.video_data, bus.ctrl, bus.ctrl_valid} !== 11'd0) begin
            failures++;
            $display("FAIL reset_video_ctrl got video=%h ctrl=%0d cv=%0b want 0", bus.video_data, bus.ctrl, bus.ctrl_valid);
        end
        checks++;
        if ({bus.terc4, bus.terc4_valid, bus.bitslip, bus.locked} !== 7'd0) begin
            failures++;
            $display("FAIL reset_terc4_align got terc4=%0d tv=%0b bs=%0b lk=%0b want 0", bus.terc4, bus.terc4_valid, bus.bitslip, bus.locked);
        end
        rst_in = 1'b0;
    endtask

    // Assumes the previous edge was a reset edge
    task automatic test_lock_acquire(input string tag);
        for (int i = 1; i <= 9; i++) begin
            bus.tmds_sym = TOK00;
            tick();
            if (i == 1) begin
                checks++;
                if (bus.ctrl_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_latency1 ctrl_valid=%0b want 0", tag, bus.ctrl_valid);
                end
            end
            if (i == 2) begin
                checks++;
                if (bus.ctrl_valid !== 1'b1 || bus.ctrl !== 2'd0) begin
                    failures++;
                    $display("FAIL %s_latency2 ctrl_valid=%0b ctrl=%0d want 1/0", tag, bus.ctrl_valid, bus.ctrl);
                end
            end
            if (i == 8) begin
                checks++;
                if (bus.locked !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_lock_cycle8 locked=%0b want 0", tag, bus.locked);
                end
            end
            if (i == 9) begin
                checks++;
                if (bus.locked !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_lock_cycle9 locked=%0b want 1", tag, bus.locked);
                end
            end
        end
    endtask

    task automatic test_ctrl_tokens();
        logic [9:0] toks [4];
        toks = '{TOK00, TOK01, TOK10, TOK11};
        for (int k = 0; k < 4; k++) begin
            bus.tmds_sym = toks[k];
            tick();
            tick();
            checks++;
            if (bus.ctrl !== 2'(k) || bus.ctrl_valid !== 1'b1 || bus.terc4_valid !== 1'b0) begin
                failures++;
                $display("FAIL ctrl_token%0d ctrl=%0d cv=%0b tv=%0b want %0d/1/0", k, bus.ctrl, bus.ctrl_valid, bus.terc4_valid, k);
            end
        end
    endtask

    task automatic test_video();
        logic [9:0] syms [4];
        logic [7:0] exp  [4];
        // 0x2FF has v=00 after inversion and XNOR chaining, hence FE
        syms = '{10'h100, 10'h2FF, 10'h200, 10'h1C3};
        exp  = '{8'h00,   8'hFE,   8'hFF,   8'h45};
        for (int k = 0; k < 4; k++) begin
            bus.tmds_sym = syms[k];
            tick();
            tick();
            checks++;
            if (bus.video_data !== exp[k] || bus.ctrl_valid !== 1'b0) begin
                failures++;
                $display("FAIL video_%h got %h cv=%0b want %h cv=0", syms[k], bus.video_data, bus.ctrl_valid, exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] syms [3];
        logic [7:0] exp  [3];
        syms = '{10'h200, 10'h1C3, 10'h100};
        exp  = '{8'hFF,   8'h45,   8'h00};
        for (int i = 0; i < 5; i++) begin
            bus.tmds_sym = (i < 3) ? syms[i] : TOK00;
            tick();
            if (i >= 1 && i <= 3) begin
                checks++;
                if (bus.video_data !== exp[i-1]) begin
                    failures++;
                    $display("FAIL b2b_%0d got %h want %h", i - 1, bus.video_data, exp[i-1]);
                end
            end
        end
    endtask

    task automatic test_terc4();
        for (int k = 0; k < 16; k++) begin
            bus.tmds_sym = terc4_tab[k];
            tick();
            tick();
            checks++;
            if (bus.terc4 !== 4'(k) || bus.terc4_valid !== 1'b1 || bus.ctrl_valid !== 1'b0) begin
                failures++;
                $display("FAIL terc4_%0d got %0d tv=%0b cv=%0b want %0d/1/0", k, bus.terc4, bus.terc4_valid, bus.ctrl_valid, k);
            end
        end
        bus.tmds_sym = 10'h3FF;
        tick();
        tick();
        checks++;
        if ({bus.terc4_valid, bus.terc4, bus.ctrl_valid, bus.ctrl} !== 8'd0) begin
            failures++;
            $display("FAIL nomatch_3ff tv=%0b t=%0d cv=%0b c=%0d want all 0", bus.terc4_valid, bus.terc4, bus.ctrl_valid, bus.ctrl);
        end
    endtask

    task automatic test_loss();
        int slips;
        slips = 0;
        repeat (12) begin bus.tmds_sym = TOK00; tick(); end
        checks++;
        if (bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_precond locked=%0b want 1", bus.locked);
        end
        repeat (2047) begin bus.tmds_sym = VID00; tick(); slips += int'(bus.bitslip); end
        repeat (4) begin bus.tmds_sym = TOK00; tick(); end
        checks++;
        if (bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_gap2047_kept locked=%0b want 1", bus.locked);
        end
        repeat (2048) begin bus.tmds_sym = VID00; tick(); slips += int'(bus.bitslip); end
        checks++;
        if (bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL loss_before_drop locked=%0b want 1", bus.locked);
        end
        tick();
        checks++;
        if (bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL loss_gap2048_drop locked=%0b want 0", bus.locked);
        end
        checks++;
        if (slips !== 0) begin
            failures++;
            $display("FAIL loss_no_bitslip pulses=%0d want 0", slips);
        end
    endtask

    task automatic test_reset_locked();
        repeat (10) begin bus.tmds_sym = TOK00; tick(); end
        checks++;
        if (bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL rstlk_precond locked=%0b want 1", bus.locked);
        end
        pulse_reset();
        checks++;
        if ({bus.locked, bus.bitslip, bus.ctrl_valid, bus.ctrl, bus.video_data, bus.terc4_valid, bus.terc4} !== 18'd0) begin
            failures++;
            $display("FAIL rstlk_outputs lk=%0b bs=%0b cv=%0b v=%h tv=%0b want all 0", bus.locked, bus.bitslip, bus.ctrl_valid, bus.video_data, bus.terc4_valid);
        end
        test_lock_acquire("relock");
    endtask

    task automatic test_reset_slip();
        int slips;
        pulse_reset();
        slips = 0;
        for (int i = 1; i <= 1024; i++) begin
            bus.tmds_sym = VID00;
            tick();
            if (i < 1024) slips += int'(bus.bitslip);
        end
        checks++;
        if (slips !== 0 || bus.bitslip !== 1'b1) begin
            failures++;
            $display("FAIL slip_timeout early=%0d at1024=%0b want 0/1", slips, bus.bitslip);
        end
        tick();
        checks++;
        if (bus.bitslip !== 1'b0) begin
            failures++;
            $display("FAIL slip_one_cycle bitslip=%0b want 0", bus.bitslip);
        end
        tick();
        pulse_reset();
        checks++;
        if ({bus.locked, bus.bitslip, bus.ctrl_valid, bus.video_data, bus.terc4_valid} !== 11'd0) begin
            failures++;
            $display("FAIL rstslip_outputs lk=%0b bs=%0b cv=%0b v=%h tv=%0b want all 0", bus.locked, bus.bitslip, bus.ctrl_valid, bus.video_data, bus.terc4_valid);
        end
        slips = 0;
        for (int i = 1; i <= 1024; i++) begin
            bus.tmds_sym = VID00;
            tick();
            if (i < 1024) slips += int'(bus.bitslip);
        end
        checks++;
        if (slips !== 0 || bus.bitslip !== 1'b1) begin
            failures++;
            $display("FAIL rstslip_no_pending early=%0d at1024=%0b want 0/1", slips, bus.bitslip);
        end
    endtask

    task automatic test_align_640();
        int rot, h, slips, last, min_gap, n, late;
        pulse_reset();
        rot = 3; h = 0; slips = 0; last = -1000; min_gap = 1000000; late = 0;
        for (n = 0; n < 6000; n++) begin
            bus.tmds_sym = rotr(line_sym(h), rot);
            tick();
            h = (h + 1) % 800;
            if (bus.bitslip === 1'b1) begin
                slips++;
                if (n - last < min_gap) min_gap = n - last;
                last = n;
                rot = (rot == 0) ? 9 : rot - 1;
            end
            if (bus.locked === 1'b1) break;
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            failures++;
            $display("FAIL align_locked locked=%0b after %0d cycles want 1", bus.locked, n);
        end
        checks++;
        if (slips !== 3) begin
            failures++;
            $display("FAIL align_slip_count pulses=%0d want 3", slips);
        end
        checks++;
        if (min_gap < 5) begin
            failures++;
            $display("FAIL align_slip_spacing min_gap=%0d want >=5", min_gap);
        end
        repeat (1600) begin
            bus.tmds_sym = rotr(line_sym(h), rot);
            tick();
            h = (h + 1) % 800;
            late += int'(bus.bitslip) + int'(!bus.locked);
        end
        checks++;
        if (late !== 0) begin
            failures++;
            $display("FAIL align_stays_locked events=%0d want 0", late);
        end
    endtask

    initial begin
        bus.tmds_sym = '0;
        test_reset();
        test_lock_acquire("acquire");
        test_ctrl_tokens();
        test_video();
        test_back_to_back();
        test_terc4();
        test_loss();
        test_reset_locked();
        test_reset_slip();
        test_align_640();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
